// File: rtl/fifo_flow_ctrl.sv
// Control FSM for the FIFO subsystem: threshold load, occupancy/idle tracking, error parking.
// Optional macro ERR_CLEAR_EN lets init leave ERROR and clear the latched error flags.
module fifo_flow_ctrl #(
  parameter int W           = 5,
  parameter int N_FIFO      = 5,
  parameter int IDLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [W-1:0]      main_fifo_low,
  input  logic [W-1:0]      main_fifo_high,
  input  logic [W-1:0]      Vc0_low,
  input  logic [W-1:0]      Vc0_high,
  input  logic [W-1:0]      Vc1_low,
  input  logic [W-1:0]      Vc1_high,
  input  logic [W-1:0]      D0_low,
  input  logic [W-1:0]      D0_high,
  input  logic [W-1:0]      D1_low,
  input  logic [W-1:0]      D1_high,
  input  logic [N_FIFO-1:0] empties,
  input  logic [N_FIFO-1:0] errors,
  output logic [W-1:0]      th_main_fifo_low,
  output logic [W-1:0]      th_main_fifo_high,
  output logic [W-1:0]      th_Vc0_low,
  output logic [W-1:0]      th_Vc0_high,
  output logic [W-1:0]      th_Vc1_low,
  output logic [W-1:0]      th_Vc1_high,
  output logic [W-1:0]      th_D0_low,
  output logic [W-1:0]      th_D0_high,
  output logic [W-1:0]      th_D1_low,
  output logic [W-1:0]      th_D1_high,
  output logic [4:0]        state,
  output logic              idle_out,
  output logic [N_FIFO-1:0] error_out,
  output logic              cfg_err
);

  localparam int CW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  // Even slots hold low thresholds, odd slots the matching high threshold.
  function automatic logic cfg_bad(input logic [9:0][W-1:0] th);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bad = bad | (th[2*i] > th[2*i+1]);
    end
    return bad;
  endfunction

  state_t             state_r;
  logic [9:0][W-1:0]  th_r;
  logic [9:0][W-1:0]  th_in_s;
  logic               idle_r;
  logic [N_FIFO-1:0]  err_r;
  logic               cfg_err_r;
  logic [CW-1:0]      idle_cnt_r;
  logic [CW-1:0]      cnt_inc_s;
  logic               cfg_bad_s;

  assign th_in_s = {D1_high, D1_low, D0_high, D0_low, Vc1_high, Vc1_low,
                    Vc0_high, Vc0_low, main_fifo_high, main_fifo_low};

  // Threshold validity and saturating increment of the all-empty counter.
  always_comb begin
    cfg_bad_s = cfg_bad(th_in_s);
    cnt_inc_s = (idle_cnt_r == {CW{1'b1}}) ? idle_cnt_r : idle_cnt_r + CW'(1);
  end

  // Controller state, thresholds and all registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RESET;
      th_r       <= '0;
      idle_r     <= 1'b0;
      err_r      <= '0;
      cfg_err_r  <= 1'b0;
      idle_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_RESET: begin
          state_r <= ST_INIT;
          idle_r  <= 1'b0;
        end
        ST_INIT: begin
          th_r <= th_in_s;
          if (!init && !cfg_bad_s) begin
            state_r   <= ST_IDLE;
            idle_r    <= 1'b1;
            cfg_err_r <= 1'b0;
          end else begin
            cfg_err_r <= cfg_bad_s;
          end
        end
        ST_IDLE: begin
          if (|errors) begin
            state_r <= ST_ERROR;
            idle_r  <= 1'b0;
            err_r   <= err_r | errors;
          end else if (init) begin
            state_r <= ST_INIT;
            idle_r  <= 1'b0;
          end else if (!(&empties)) begin
            state_r <= ST_ACTIVE;
            idle_r  <= 1'b0;
          end else begin
            idle_r  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (|errors) begin
            state_r    <= ST_ERROR;
            err_r      <= err_r | errors;
            idle_cnt_r <= '0;
          end else if (init) begin
            state_r    <= ST_INIT;
            idle_cnt_r <= '0;
          end else if (&empties) begin
            if (cnt_inc_s == CW'(IDLE_CYCLES)) begin
              state_r    <= ST_IDLE;
              idle_r     <= 1'b1;
              idle_cnt_r <= '0;
            end else begin
              idle_cnt_r <= cnt_inc_s;
            end
          end else begin
            idle_cnt_r <= '0;
          end
        end
        ST_ERROR: begin
`ifdef ERR_CLEAR_EN
          if (init) begin
            state_r <= ST_INIT;
            err_r   <= '0;
          end else begin
            err_r   <= err_r | errors;
          end
`else
          err_r <= err_r | errors;
`endif
        end
        default: begin
          state_r    <= ST_RESET;
          idle_r     <= 1'b0;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  assign state             = state_r;
  assign idle_out          = idle_r;
  assign error_out         = err_r;
  assign cfg_err           = cfg_err_r;
  assign th_main_fifo_low  = th_r[0];
  assign th_main_fifo_high = th_r[1];
  assign th_Vc0_low        = th_r[2];
  assign th_Vc0_high       = th_r[3];
  assign th_Vc1_low        = th_r[4];
  assign th_Vc1_high       = th_r[5];
  assign th_D0_low         = th_r[6];
  assign th_D0_high        = th_r[7];
  assign th_D1_low         = th_r[8];
  assign th_D1_high        = th_r[9];

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl: reset, threshold load, cfg error, idle tracking, error parking.
module tb_fifo_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b1;
  logic [4:0] main_fifo_low = '0, main_fifo_high = '0, Vc0_low = '0, Vc0_high = '0;
  logic [4:0] Vc1_low = '0, Vc1_high = '0, D0_low = '0, D0_high = '0, D1_low = '0, D1_high = '0;
  logic [4:0] empties = 5'b11111;
  logic [4:0] errors = 5'b00000;
  logic [4:0] th_main_fifo_low, th_main_fifo_high, th_Vc0_low, th_Vc0_high, th_Vc1_low;
  logic [4:0] th_Vc1_high, th_D0_low, th_D0_high, th_D1_low, th_D1_high;
  logic [4:0] state;
  logic       idle_out;
  logic [4:0] error_out;
  logic       cfg_err;

  int checks = 0;
  int err_cnt = 0;

  fifo_flow_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .main_fifo_low(main_fifo_low), .main_fifo_high(main_fifo_high),
    .Vc0_low(Vc0_low), .Vc0_high(Vc0_high), .Vc1_low(Vc1_low), .Vc1_high(Vc1_high),
    .D0_low(D0_low), .D0_high(D0_high), .D1_low(D1_low), .D1_high(D1_high),
    .empties(empties), .errors(errors),
    .th_main_fifo_low(th_main_fifo_low), .th_main_fifo_high(th_main_fifo_high),
    .th_Vc0_low(th_Vc0_low), .th_Vc0_high(th_Vc0_high),
    .th_Vc1_low(th_Vc1_low), .th_Vc1_high(th_Vc1_high),
    .th_D0_low(th_D0_low), .th_D0_high(th_D0_high),
    .th_D1_low(th_D1_low), .th_D1_high(th_D1_high),
    .state(state), .idle_out(idle_out), .error_out(error_out), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset held for two clocks, then release
    tick();
    tick();
    check("rst_state", 32'(state), 32'h01);
    check("rst_th_main_lo", 32'(th_main_fifo_low), 32'h00);
    check("rst_idle", 32'(idle_out), 32'h0);
    check("rst_err_out", 32'(error_out), 32'h00);
    check("rst_cfg_err", 32'(cfg_err), 32'h0);
    reset = 1'b1;
    check("rel_state", 32'(state), 32'h01);
    tick();
    check("init_state", 32'(state), 32'h02);
    check("init_th_d1_hi", 32'(th_D1_high), 32'h00);

    // 2: load thresholds, then drop init
    main_fifo_low = 5'd3; main_fifo_high = 5'd10;
    Vc0_low = 5'd2; Vc0_high = 5'd8;
    Vc1_low = 5'd4; Vc1_high = 5'd12;
    D0_low = 5'd1; D0_high = 5'd1;
    D1_low = 5'd5; D1_high = 5'd20;
    tick();
    check("load_state", 32'(state), 32'h02);
    check("load_th_main_lo", 32'(th_main_fifo_low), 32'd3);
    init = 1'b0;
    tick();
    check("idle_state", 32'(state), 32'h04);
    check("idle_out", 32'(idle_out), 32'h1);
    check("th_main_hi", 32'(th_main_fifo_high), 32'd10);
    check("th_vc0_lo", 32'(th_Vc0_low), 32'd2);
    check("th_vc0_hi", 32'(th_Vc0_high), 32'd8);
    check("th_d0_lo", 32'(th_D0_low), 32'd1);
    check("th_d0_hi", 32'(th_D0_high), 32'd1);
    check("th_d1_hi", 32'(th_D1_high), 32'd20);
    main_fifo_low = 5'd7;
    tick();
    check("th_hold", 32'(th_main_fifo_low), 32'd3);

    // 3: re-init with low > high on VC1
    init = 1'b1;
    tick();
    check("reinit_state", 32'(state), 32'h02);
    Vc1_low = 5'd9; Vc1_high = 5'd4; init = 1'b0;
    tick();
    check("cfg_err_set", 32'(cfg_err), 32'h1);
    check("cfg_stay_init", 32'(state), 32'h02);
    tick();
    check("cfg_stay_init2", 32'(state), 32'h02);
    Vc1_high = 5'd12;
    tick();
    check("cfg_fix_state", 32'(state), 32'h04);
    check("cfg_err_clr", 32'(cfg_err), 32'h0);
    check("th_vc1_hi", 32'(th_Vc1_high), 32'd12);
    check("th_vc1_lo", 32'(th_Vc1_low), 32'd9);
    check("th_main_reload", 32'(th_main_fifo_low), 32'd7);

    // 4: idle/active tracking
    empties = 5'b11110;
    tick();
    check("act_state", 32'(state), 32'h08);
    check("act_idle_out", 32'(idle_out), 32'h0);
    empties = 5'b11111;
    tick();
    check("act_one_empty", 32'(state), 32'h08);
    empties = 5'b11110;
    tick();
    check("act_cnt_clear", 32'(state), 32'h08);
    empties = 5'b11111;
    tick();
    check("act_empty1", 32'(state), 32'h08);
    tick();
    check("back_idle", 32'(state), 32'h04);
    check("back_idle_out", 32'(idle_out), 32'h1);
    empties = 5'b11110;
    tick();
    check("act_again", 32'(state), 32'h08);

    // 5: error beats init, then accumulates
    errors = 5'b00100; init = 1'b1;
    tick();
    check("err_state", 32'(state), 32'h10);
    check("err_out1", 32'(error_out), 32'h04);
    errors = 5'b00001; init = 1'b0;
    tick();
    check("err_out2", 32'(error_out), 32'h05);
    errors = 5'b00000; init = 1'b1;
    tick();
`ifdef ERR_CLEAR_EN
    check("err_clear_state", 32'(state), 32'h02);
    check("err_clear_out", 32'(error_out), 32'h00);
`else
    check("err_terminal", 32'(state), 32'h10);
    check("err_hold_out", 32'(error_out), 32'h05);
`endif

    // 6: asynchronous reset mid-INIT and mid-ACTIVE
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("pre_midinit_th", 32'(th_main_fifo_low), 32'd7);
    #2 reset = 1'b0;
    #1;
    check("midinit_state", 32'(state), 32'h01);
    check("midinit_th", 32'(th_main_fifo_low), 32'd0);
    reset = 1'b1;
    init = 1'b0;
    empties = 5'b11111;
    tick();
    tick();
    check("re_idle", 32'(state), 32'h04);
    empties = 5'b11110;
    tick();
    check("re_active", 32'(state), 32'h08);
    #3 reset = 1'b0;
    #1;
    check("async_state", 32'(state), 32'h01);
    check("async_err_out", 32'(error_out), 32'h00);
    check("async_th", 32'(th_Vc1_low), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, err_cnt);
    $finish;
  end

endmodule
